// File: rtl/lcd_status_sequencer.sv
// Status-code feeder for the 16x2 character-LCD driver.
// Buffers recorder status requests in a small FIFO and hands them to the driver one at a
// time, using the driver's READY as a two-edge handshake and holding each code for a
// minimum dwell so every status string is completely written before the next change.
module lcd_status_sequencer #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned DWELL_CYCLES   = 3600,
    parameter int unsigned TIMEOUT_CYCLES = 24000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_req_valid,
    input  logic [2:0] i_req_code,
    output logic       o_req_ready,
    input  logic       i_lcd_ready,
    output logic [2:0] o_input_state,
    output logic [2:0] o_shown,
    output logic       o_busy,
    output logic       o_err_timeout,
    output logic [7:0] o_drop_cnt
);

    localparam int unsigned AW           = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [15:0] DWELL_LAST   = 16'(DWELL_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]  CODE_BLANK   = 3'b001;

    typedef enum logic [2:0] {
        StBoot,
        StIdle,
        StWaitIdle,
        StWaitTake,
        StDwell
    } state_e;

    state_e          state_q, state_d;
    logic [15:0]     timer_q, timer_d;
    logic [2:0]      input_state_q, input_state_d;
    logic [2:0]      shown_q, shown_d;
    logic            err_q, err_d;
    logic [7:0]      drop_q;

    logic [2:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q;

    logic            full, empty;
    logic [2:0]      head, tail, ref_code;
    logic            code_ok, accept, push_en, pop_en, drop_en;

    // FIFO status and request classification
    always_comb begin
        full     = (count_q == (AW+1)'(FIFO_DEPTH));
        empty    = (count_q == '0);
        head     = mem[rd_ptr_q];
        tail     = mem[wr_ptr_q - AW'(1)];
        // With nothing queued, a request repeating what is on screen is redundant.
        ref_code = empty ? shown_q : tail;
        code_ok  = (i_req_code != 3'b000) && (i_req_code <= 3'b101);
        accept   = i_req_valid && !full;
        push_en  = accept && code_ok && (i_req_code != ref_code);
        drop_en  = accept && !push_en;
        pop_en   = (state_q == StIdle) && !empty;
    end

    // FIFO storage; contents need no reset because the pointers define validity
    always_ff @(posedge i_clk) begin
        if (push_en) begin
            mem[wr_ptr_q] <= i_req_code;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push_en && !pop_en) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (pop_en && !push_en) begin
                count_q <= count_q - (AW+1)'(1);
            end
        end
    end

    // Saturating count of requests accepted but not queued
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            drop_q <= '0;
        end else if (drop_en && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    // Handshake FSM next-state; the timer is shared by both wait states so their combined
    // residence is bounded by TIMEOUT_CYCLES
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        input_state_d = input_state_q;
        shown_d       = shown_q;
        err_d         = err_q;
        unique case (state_q)
            StBoot: begin
                if (i_lcd_ready) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                // A head equal to the shown code is popped and discarded without LCD activity.
                if (!empty && (head != shown_q)) begin
                    input_state_d = head;
                    timer_d       = '0;
                    state_d       = StWaitIdle;
                end
            end
            StWaitIdle: begin
                if (i_lcd_ready) begin
                    if (input_state_q == CODE_BLANK) begin
                        // Blank needs no take edge: the driver clears and stays idle.
                        shown_d = input_state_q;
                        timer_d = '0;
                        state_d = StDwell;
                    end else begin
                        timer_d = timer_q + 16'd1;
                        state_d = StWaitTake;
                    end
                end else if (timer_q >= TIMEOUT_LAST) begin
                    err_d   = 1'b1;
                    state_d = StBoot;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            StWaitTake: begin
                if (!i_lcd_ready) begin
                    shown_d = input_state_q;
                    timer_d = '0;
                    state_d = StDwell;
                end else if (timer_q >= TIMEOUT_LAST) begin
                    err_d   = 1'b1;
                    state_d = StBoot;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            StDwell: begin
                if (timer_q >= DWELL_LAST) begin
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            default: begin
                state_d = StBoot;
            end
        endcase
    end

    // Handshake FSM state and registered outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= StBoot;
            timer_q       <= '0;
            input_state_q <= CODE_BLANK;
            shown_q       <= CODE_BLANK;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            input_state_q <= input_state_d;
            shown_q       <= shown_d;
            err_q         <= err_d;
        end
    end

    // Output mapping
    always_comb begin
        o_req_ready   = !full;
        o_input_state = input_state_q;
        o_shown       = shown_q;
        o_busy        = (state_q != StIdle) || !empty;
        o_err_timeout = err_q;
        o_drop_cnt    = drop_q;
    end

endmodule

// File: doc/lcd_status_sequencer.md
Name: lcd_status_sequencer

Overview:
- Upstream feeder for the 16x2 character-LCD driver in the audio recorder top level.
- Accepts status-change requests (RECORD/STOP/PLAY/PAUSE/blank) from the recorder control FSM and buffers them in a small FIFO.
- Presents one 3-bit state code at a time on the driver's INPUT_STATE input, using the driver's READY output as the handshake.
- Enforces a minimum display dwell time so every status string is fully written before the next change.

Parameters:
FIFO_DEPTH, 4, request queue entries (power of 2, 2..16)
DWELL_CYCLES, 3600, minimum cycles a newly issued code is held after acceptance (6 chars x 43us at 12 MHz, plus margin)
TIMEOUT_CYCLES, 24000, max cycles waiting on a handshake edge (2 ms, above the 1.53 ms clear time)

Ports:
i_clk  in  1  clock, 12 MHz
i_rst  in  1  reset, asynchronous, active-high
i_req_valid  in  1  status request strobe
i_req_code  in  3  requested code: 001 IDLE(blank), 010 RECORD, 011 STOP, 100 PLAY, 101 PAUSE
o_req_ready  out  1  FIFO not full; a request is accepted when i_req_valid && o_req_ready
i_lcd_ready  in  1  READY from the LCD driver; high only while the driver sits in its IDLE state
o_input_state  out  3  code driven to the LCD driver's INPUT_STATE
o_shown  out  3  last code whose handshake completed
o_busy  out  1  high in any state other than S_IDLE, or while the FIFO is non-empty
o_err_timeout  out  1  sticky handshake-timeout flag; cleared only by reset
o_drop_cnt  out  8  count of rejected requests, saturates at 255

Behaviour:
- Reset values:
  - o_input_state=001, o_shown=001, o_err_timeout=0, o_drop_cnt=0.
  - FIFO empty; o_req_ready=1.
  - FSM in S_BOOT; o_busy=1.
- Request intake:
  - Codes 000, 110 and 111 are accepted (ready asserted) but not stored, and o_drop_cnt increments.
  - A valid code equal to the FIFO tail entry (or to o_shown when the FIFO is empty) is also dropped and counted, so identical consecutive requests coalesce.
  - Push and pop in the same cycle are legal. When full, o_req_ready=0 and the request is held off, not dropped.
- FSM, one transition per clock:
  - S_BOOT: hold o_input_state=001. Wait for i_lcd_ready=1, which marks the end of driver power-up init (about 21 ms). No timeout in this state. Then go to S_IDLE.
  - S_IDLE: if the FIFO is non-empty, pop head C.
    - If C==o_shown: discard C, stay in S_IDLE (1 cycle, no LCD activity).
    - Otherwise: drive o_input_state=C on the next cycle, clear the timer, go to S_WAIT_IDLE.
  - S_WAIT_IDLE: wait for i_lcd_ready=1, meaning the driver has finished its clear and reached IDLE.
    - If the previous code was 001, this is already true in the first cycle.
    - On ready: if C==001, go to S_DWELL. Otherwise go to S_WAIT_TAKE.
  - S_WAIT_TAKE: wait for i_lcd_ready=0, meaning the driver sampled C and left IDLE. Then go to S_DWELL.
  - S_DWELL: on entry, o_shown<=C and the timer clears. Count DWELL_CYCLES, then go to S_IDLE.
- Timeout:
  - The timer is 16 bits and is shared between the wait states.
  - If S_WAIT_IDLE or S_WAIT_TAKE lasts TIMEOUT_CYCLES: set o_err_timeout, leave o_shown unchanged, go to S_BOOT.
  - o_input_state keeps C. The FIFO contents are kept.
- Output stability: o_input_state changes only on the S_IDLE to S_WAIT_IDLE transition and on reset.
- Asynchronous reset mid-sequence: everything returns to reset values immediately. The FIFO is flushed.

Test Plan:
1. Reset, i_lcd_ready=0 for 1000 cycles then 1 -> FSM stays in S_BOOT with o_input_state=001 until ready rises, then reaches S_IDLE. o_busy falls one cycle later.
2. Push 010 with a driver model (ready low ~20 cycles in clear, 1-cycle ready pulse, then low) -> o_input_state=010 one cycle after the pop. o_shown=010 after ready falls. The next pop occurs no earlier than 3600 cycles later.
3. Push 010,010,011,100,101,001 back-to-back with the driver busy -> duplicate 010 dropped (o_drop_cnt=1). Fifth distinct push sees o_req_ready=0 until the first pop. All codes are issued in order.
4. Push code 111 and code 000 -> both accepted and discarded, o_drop_cnt=2, o_input_state unchanged. Then force 300 drops -> o_drop_cnt saturates at 255.
5. After issuing 100, hold i_lcd_ready=0 -> after 24000 cycles o_err_timeout=1 and FSM returns to S_BOOT. Raising ready resumes draining the queued entries.
6. Assert i_rst during S_DWELL with 2 entries queued -> all outputs immediately at reset values and the FIFO is empty.
